board_io_ctrl: RTL and testbench

Parametrised board I/O front end for the SoC top level. It synchronises the slide switches and push buttons, and debounces each button with a press pulse. It drives the LED bank in one of four switch-selected display modes. It replaces the fixed switch-to-LED mirror with a reusable, width-generic block that downstream test logic can also consume.

---
 rtl/board_io_ctrl.sv | 86 ++++++++
 tb/tb_board_io_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/board_io_ctrl.sv
// board_io_ctrl: synchronised switches, debounced buttons with press pulses, and a
// four-mode LED display (switch mirror, press counter, blink, rotator).
module board_io_ctrl #(
  parameter int N_BTN           = 5,
  parameter int N_SW            = 16,
  parameter int N_LED           = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_DIV       = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  input  logic [N_SW-1:0]  sw,
  output logic [N_LED-1:0] led,
  output logic [N_BTN-1:0] btn_db,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_SW-1:0]  sw_sync,
  output logic [1:0]       mode
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DW = $clog2(BLINK_DIV);
  logic [N_BTN-1:0] btn_s1_q, btn_s2_q, btn_db_q, btn_db_d, btn_press_q, btn_press_d;
  logic [CW-1:0]    cnt_q [N_BTN];
  logic [CW-1:0]    cnt_d [N_BTN];
  logic [N_SW-1:0]  sw_s1_q, sw_sync_q;
  logic [DW-1:0]    div_q;
  logic [N_LED-1:0] press_cnt_q, press_cnt_d, rot_q, led_q, led_d;
  logic             blink_q, tick;
  assign mode = sw_sync_q[N_SW-1 -: 2];
  assign tick = div_q == DW'(BLINK_DIV - 1);
  assign press_cnt_d = btn_press_q[1] ? '0 : btn_press_q[0] ? press_cnt_q + N_LED'(1) : press_cnt_q;
  assign led_d = mode == 2'b00 ? sw_sync_q[N_LED-1:0] :
                 mode == 2'b01 ? press_cnt_q :
                 mode == 2'b10 ? {N_LED{blink_q}} : rot_q;
  // Any cycle where the synced level matches the accepted level restarts the count.
  always_comb begin
    btn_db_d    = btn_db_q;
    btn_press_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = '0;
      if (btn_s2_q[i] != btn_db_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          btn_db_d[i]    = btn_s2_q[i];
          btn_press_d[i] = btn_s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1_q    <= '0;
      btn_s2_q    <= '0;
      btn_db_q    <= '0;
      btn_press_q <= '0;
      cnt_q       <= '{default: '0};
      sw_s1_q     <= '0;
      sw_sync_q   <= '0;
      div_q       <= '0;
      press_cnt_q <= '0;
      rot_q       <= N_LED'(1);
      blink_q     <= 1'b0;
      led_q       <= '0;
    end else begin
      btn_s1_q    <= btn;
      btn_s2_q    <= btn_s1_q;
      btn_db_q    <= btn_db_d;
      btn_press_q <= btn_press_d;
      cnt_q       <= cnt_d;
      sw_s1_q     <= sw;
      sw_sync_q   <= sw_s1_q;
      div_q       <= tick ? '0 : div_q + DW'(1);
      press_cnt_q <= press_cnt_d;
      led_q       <= led_d;
      if (tick) begin
        blink_q <= ~blink_q;
        rot_q   <= {rot_q[N_LED-2:0], rot_q[N_LED-1]};
      end
    end
  end
  assign led       = led_q;
  assign btn_db    = btn_db_q;
  assign btn_press = btn_press_q;
  assign sw_sync   = sw_sync_q;
endmodule

// File: tb/tb_board_io_ctrl.sv
// tb_board_io_ctrl: directed and random stimulus, expected outputs queued from a
// history-based reference model and checked every cycle by an independent monitor.
module tb_board_io_ctrl;
  localparam int NB = 5, NS = 16, NL = 8, DC = 4, BD = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic [NB-1:0] btn = '0;
  logic [NS-1:0] sw = '0;
  logic [NL-1:0] led;
  logic [NB-1:0] btn_db, btn_press;
  logic [NS-1:0] sw_sync;
  logic [1:0] mode;
  typedef struct packed {
    logic [NL-1:0] led;
    logic [NB-1:0] db;
    logic [NB-1:0] pr;
    logic [NS-1:0] sws;
    logic [1:0]    mode;
  } exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0;
  board_io_ctrl #(.N_BTN(NB), .N_SW(NS), .N_LED(NL), .DEBOUNCE_CYCLES(DC), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .btn(btn), .sw(sw), .led(led), .btn_db(btn_db),
    .btn_press(btn_press), .sw_sync(sw_sync), .mode(mode));
  always #5 clk = ~clk;
  // Reference model: state visible after each clock edge.
  logic [NL-1:0] m_led, m_cnt;
  logic [NB-1:0] m_db, m_pr;
  logic [NS-1:0] m_sws;
  int n_edges;
  logic [NB-1:0] raw_q[$], s_hist[$];
  logic [NS-1:0] sw_q[$];
  task automatic model(input logic [NB-1:0] b, input logic [NS-1:0] s, input logic r);
    logic [NL-1:0] rot_old, led_new, cnt_new;
    logic [NB-1:0] sv, db_new, pr_new;
    logic [NS-1:0] sws_new;
    logic blink_old, all_diff;
    if (r) begin
      m_led = '0; m_cnt = '0; m_db = '0; m_pr = '0; m_sws = '0; n_edges = 0;
      raw_q = '{NB'(0), NB'(0)}; sw_q = '{NS'(0)}; s_hist = {};
    end else begin
      rot_old   = NL'(1) << ((n_edges / BD) % NL);
      blink_old = ((n_edges / BD) % 2) == 1;
      case (m_sws[NS-1 -: 2])
        2'd0: led_new = m_sws[NL-1:0];
        2'd1: led_new = m_cnt;
        2'd2: led_new = blink_old ? '1 : '0;
        default: led_new = rot_old;
      endcase
      cnt_new = m_pr[1] ? '0 : m_pr[0] ? m_cnt + 1 : m_cnt;
      sv = raw_q.pop_front(); raw_q.push_back(b);
      s_hist.push_back(sv);
      if (s_hist.size() > DC) void'(s_hist.pop_front());
      db_new = m_db; pr_new = '0;
      for (int i = 0; i < NB; i++) begin
        all_diff = s_hist.size() == DC;
        foreach (s_hist[j]) if (s_hist[j][i] == m_db[i]) all_diff = 1'b0;
        if (all_diff) begin db_new[i] = ~m_db[i]; pr_new[i] = db_new[i]; end
      end
      sws_new = sw_q.pop_front(); sw_q.push_back(s);
      m_led = led_new; m_cnt = cnt_new; m_db = db_new; m_pr = pr_new; m_sws = sws_new;
      n_edges++;
    end
    sb.push_back('{led: m_led, db: m_db, pr: m_pr, sws: m_sws, mode: m_sws[NS-1 -: 2]});
  endtask
  task automatic step(input logic [NB-1:0] b, input logic [NS-1:0] s, input logic r);
    @(negedge clk);
    btn = b; sw = s; rst = r;
    model(b, s, r);
  endtask
  task automatic hold(input logic [NB-1:0] b, input logic [NS-1:0] s, input int n);
    repeat (n) step(b, s, 1'b0);
  endtask
  task automatic press(input logic [NB-1:0] b, input logic [NS-1:0] s);
    hold(b, s, 8);
    hold('0, s, 8);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if ({led, btn_db, btn_press, sw_sync, mode} !== e) begin
          miscompares++;
          $display("FAIL vec %0d t=%0t: led=%h db=%h press=%h sw_sync=%h mode=%0d, want led=%h db=%h press=%h sw_sync=%h mode=%0d",
                   vectors, $time, led, btn_db, btn_press, sw_sync, mode, e.led, e.db, e.pr, e.sws, e.mode);
        end
      end
    end
  end
  initial begin
    logic [NB-1:0] rb;
    logic [NS-1:0] rs;
    step('0, '0, 1'b1); step('0, '0, 1'b1);
    hold('0, 16'h0000, 3);
    hold('0, 16'h00A5, 5);
    hold(5'b00001, 16'h00A5, 3);
    hold('0, 16'h00A5, 1);
    hold(5'b00001, 16'h00A5, 10);
    hold('0, 16'h00A5, 10);
    repeat (3) press(5'b00001, 16'h4000);
    repeat (256) press(5'b00001, 16'h4000);
    press(5'b00011, 16'h4000);
    hold('0, 16'h4000, 4);
    step('0, 16'hC000, 1'b1);
    hold('0, 16'hC000, 30);
    hold('0, 16'h8000, 20);
    hold(5'b00001, 16'hC000, 4);
    step(5'b00001, 16'hC000, 1'b1);
    hold(5'b00001, 16'hC000, 2);
    hold('0, 16'hC000, 20);
    repeat (300) begin
      rb = NB'($urandom);
      rs = NS'($urandom);
      if ($urandom_range(0, 60) == 0) step(rb, rs, 1'b1);
      else hold(rb, rs, $urandom_range(1, 9));
    end
    hold('0, '0, 3);
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors never checked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
